// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad debouncer: FSM states, default timing
// constants and a counter-width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 51;
  localparam int DEFAULT_REPEAT_CYCLES   = 5000000;

  // Bits needed to hold the values 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Loadable saturating up-counter. reach fires on the cycle the count arrives
// at LIMIT; done stays high while it sits there.
module debounce_timer
  import keypad_pkg::*;
#(
  parameter int LIMIT = 1,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done,
  output logic         reach
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (en && (count != LIM)) begin
      count_d = count + W'(1);
    end
  end

  assign done = (count == LIM);
  // A counter parked at LIMIT only fires again if it is explicitly reloaded.
  assign reach = (count_d == LIM) && (load || !done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces a scanned keypad: qualifies presses and releases over a run of
// stable samples, with optional auto-repeat while a key is held.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int CODE_W          = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_active,
  input  logic [CODE_W-1:0] key_code,
  output logic [CODE_W-1:0] code_out,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              held
);

  localparam int ST_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RP_W = cnt_width(REPEAT_CYCLES);

  state_t state, state_d;
  logic [CODE_W-1:0] cand, cand_d;

  logic            st_load, st_en, st_done, st_reach;
  logic [ST_W-1:0] st_val;
  logic            rp_load, rp_en, rp_done, rp_reach;
  logic [RP_W-1:0] rp_val;

  logic accept, release_ev, repeat_ev;

  debounce_timer #(.LIMIT(DEBOUNCE_CYCLES), .W(ST_W)) u_stable (
    .clk      (clk),
    .rst      (reset),
    .load     (st_load),
    .load_val (st_val),
    .en       (st_en),
    .done     (st_done),
    .reach    (st_reach)
  );

  debounce_timer #(.LIMIT(REPEAT_CYCLES), .W(RP_W)) u_repeat (
    .clk      (clk),
    .rst      (reset),
    .load     (rp_load),
    .load_val (rp_val),
    .en       (rp_en),
    .done     (rp_done),
    .reach    (rp_reach)
  );

  // Timer controls depend only on state and inputs, never on reach, so the
  // next-state logic below can use reach without forming a loop.
  always_comb begin
    st_load = 1'b0;
    st_val  = '0;
    st_en   = 1'b0;
    rp_load = 1'b1;
    rp_val  = '0;
    rp_en   = 1'b0;
    cand_d  = cand;
    unique case (state)
      IDLE: begin
        st_load = 1'b1;
        if (key_active) begin
          st_val = ST_W'(1);
          cand_d = key_code;
        end
      end
      PRESS_WAIT: begin
        if (!key_active) begin
          st_load = 1'b1;
        end else if (key_code != cand) begin
          st_load = 1'b1;
          st_val  = ST_W'(1);
          cand_d  = key_code;
        end else begin
          st_en = !st_done;
        end
      end
      HELD: begin
        st_load = 1'b1;
        if (!key_active) begin
          st_val = ST_W'(1);
        end else if (REPEAT_EN != 0) begin
          // Restart at 1 after a repeat so the period stays REPEAT_CYCLES.
          if (rp_done) begin
            rp_val = RP_W'(1);
          end else begin
            rp_load = 1'b0;
            rp_en   = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (key_active) begin
          st_load = 1'b1;
        end else begin
          st_en = !st_done;
        end
      end
      default: st_load = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    release_ev = 1'b0;
    repeat_ev  = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_active) begin
          accept  = st_reach;
          state_d = st_reach ? HELD : PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_active) begin
          state_d = IDLE;
        end else if (st_reach) begin
          accept  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!key_active) begin
          release_ev = st_reach;
          state_d    = st_reach ? IDLE : RELEASE_WAIT;
        end else begin
          repeat_ev = rp_reach;
        end
      end
      RELEASE_WAIT: begin
        if (key_active) begin
          state_d = HELD;
        end else if (st_reach) begin
          release_ev = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cand          <= '0;
      code_out      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      cand          <= cand_d;
      press_pulse   <= accept || repeat_ev;
      release_pulse <= release_ev;
      held          <= (state_d == HELD) || (state_d == RELEASE_WAIT);
      if (accept) begin
        code_out <= cand_d;
      end
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer: two instances (repeat off / on) share stimulus;
// each sample's expected outputs are queued when driven and checked next cycle.
module tb_keypad_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_active = 1'b0;
  logic [7:0] key_code = 8'h00;

  logic [7:0] code0, code1;
  logic       press0, press1, rel0, rel1, held0, held1;

  keypad_debouncer #(.CODE_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .key_active(key_active), .key_code(key_code),
    .code_out(code0), .press_pulse(press0), .release_pulse(rel0), .held(held0)
  );

  keypad_debouncer #(.CODE_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_CYCLES(10)) dut1 (
    .clk(clk), .reset(reset), .key_active(key_active), .key_code(key_code),
    .code_out(code1), .press_pulse(press1), .release_pulse(rel1), .held(held1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ka;
    logic [7:0] code;
    logic       press;
    logic       rel;
    logic       held;
    logic [7:0] cout;
    logic       press1;
    logic       chk1;
  } vec_t;

  vec_t tbl [26];
  vec_t sb [$];
  logic bounce_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ka, input logic [7:0] c, input logic p,
                              input logic r, input logic h, input logic [7:0] co,
                              input logic p1, input logic chk1);
    vec_t v;
    v.ka = ka; v.code = c; v.press = p; v.rel = r; v.held = h;
    v.cout = co; v.press1 = p1; v.chk1 = chk1;
    return v;
  endfunction

  // Drive one sample at the falling edge, let the rising edge take it, then
  // compare the registered outputs at the following falling edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    key_active = v.ka;
    key_code   = v.code;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "/press"}, {7'd0, press0}, {7'd0, e.press});
    check({tag, "/release"}, {7'd0, rel0}, {7'd0, e.rel});
    check({tag, "/held"}, {7'd0, held0}, {7'd0, e.held});
    check({tag, "/code"}, code0, e.cout);
    check({tag, "/excl"}, {7'd0, press0 & rel0}, 8'd0);
    if (e.chk1) begin
      check({tag, "/rpt_press"}, {7'd0, press1}, {7'd0, e.press1});
      check({tag, "/rpt_release"}, {7'd0, rel1}, {7'd0, e.rel});
      check({tag, "/rpt_held"}, {7'd0, held1}, {7'd0, e.held});
      check({tag, "/rpt_code"}, code1, e.cout);
    end
  endtask

  initial begin
    // Clean press table: 20 high samples of 8'h3A, 4 low, 2 idle.
    for (int i = 0; i < 20; i++)
      tbl[i] = mk(1'b1, 8'h3A, i == 3, 1'b0, i >= 3, (i >= 3) ? 8'h3A : 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++)
      tbl[20 + j] = mk(1'b0, 8'h00, 1'b0, j == 3, j < 3, 8'h3A, 1'b0, 1'b0);
    for (int j = 24; j < 26; j++)
      tbl[j] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b1);

    #2 reset = 1'b1;
    #1;
    check("reset/press", {7'd0, press0}, 8'd0);
    check("reset/release", {7'd0, rel0}, 8'd0);
    check("reset/held", {7'd0, held0}, 8'd0);
    check("reset/code", code0, 8'h00);
    check("reset/rpt_code", code1, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) step(tbl[i], $sformatf("clean[%0d]", i));

    for (int k = 0; k < 7; k++)
      step(mk(bounce_pat[k], 8'h05, k == 6, 1'b0, k == 6, (k == 6) ? 8'h05 : 8'h3A, k == 6, 1'b1),
           $sformatf("bounce[%0d]", k));
    for (int j = 0; j < 4; j++)
      step(mk(1'b0, 8'h00, 1'b0, j == 3, j < 3, 8'h05, 1'b0, 1'b1), $sformatf("bounce_rel[%0d]", j));

    for (int k = 0; k < 2; k++)
      step(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1), $sformatf("chg11[%0d]", k));
    for (int k = 0; k < 4; k++)
      step(mk(1'b1, 8'h22, k == 3, 1'b0, k == 3, (k == 3) ? 8'h22 : 8'h05, k == 3, 1'b1),
           $sformatf("chg22[%0d]", k));
    step(mk(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1), "held_code_ignored");
    for (int k = 0; k < 2; k++)
      step(mk(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1), $sformatf("glitch_low[%0d]", k));
    for (int k = 0; k < 3; k++)
      step(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1), $sformatf("glitch_back[%0d]", k));
    for (int j = 0; j < 4; j++)
      step(mk(1'b0, 8'h00, 1'b0, j == 3, j < 3, 8'h22, 1'b0, 1'b1), $sformatf("chg_rel[%0d]", j));

    for (int i = 0; i < 39; i++)
      step(mk(1'b1, 8'h4C, i == 3, 1'b0, i >= 3, (i >= 3) ? 8'h4C : 8'h22,
              (i == 3) || (i == 13) || (i == 23) || (i == 33), 1'b1),
           $sformatf("repeat[%0d]", i));
    for (int j = 0; j < 4; j++)
      step(mk(1'b0, 8'h00, 1'b0, j == 3, j < 3, 8'h4C, 1'b0, 1'b1), $sformatf("repeat_rel[%0d]", j));

    for (int k = 0; k < 3; k++)
      step(mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h4C, 1'b0, 1'b1), $sformatf("prereset[%0d]", k));
    reset = 1'b1;
    #1;
    check("midreset/code", code0, 8'h00);
    check("midreset/rpt_code", code1, 8'h00);
    check("midreset/held", {7'd0, held0}, 8'd0);
    check("midreset/press", {7'd0, press0}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    check("inreset/press", {7'd0, press0}, 8'd0);
    check("inreset/release", {7'd0, rel0}, 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++)
      step(mk(1'b1, 8'h66, k == 3, 1'b0, k == 3, (k == 3) ? 8'h66 : 8'h00, k == 3, 1'b1),
           $sformatf("postreset[%0d]", k));
    for (int j = 0; j < 4; j++)
      step(mk(1'b0, 8'h00, 1'b0, j == 3, j < 3, 8'h66, 1'b0, 1'b1), $sformatf("postreset_rel[%0d]", j));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
